// File: rtl/bp_cfg_reader.sv
// Configuration reader: returns fields of a built-in constant parameter table,
// either one field per request or all eight fields as a multi-beat dump.
module bp_cfg_reader #(
    parameter int cfg_id_width_p = 7,
    parameter int data_width_p   = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [cfg_id_width_p-1:0] cfg_id_i,
    input  logic                      req_v_i,
    input  logic [2:0]                req_field_i,
    input  logic                      req_dump_i,
    output logic                      req_ready_o,
    output logic                      resp_v_o,
    output logic [data_width_p-1:0]   resp_data_o,
    output logic [2:0]                resp_field_o,
    output logic                      resp_err_o,
    output logic                      resp_last_o,
    input  logic                      resp_yumi_i
);

    // The state tracks beats still to come after the one on the output. The
    // final beat (and a single read's only beat) is presented in e_idle so a
    // new request can be taken in the same cycle that beat is consumed.
    typedef enum logic [1:0] {e_idle, e_single, e_dump} state_e;

    state_e                    state_reg;
    logic [cfg_id_width_p-1:0] cfg_reg;
    logic                      resp_v_reg;
    logic [data_width_p-1:0]   resp_data_reg;
    logic [2:0]                resp_field_reg;
    logic                      resp_err_reg;
    logic                      resp_last_reg;

    logic                      accept;
    logic [2:0]                first_field;
    logic [2:0]                next_field;
    logic                      req_impl;
    logic [9:0]                req_val;
    logic [9:0]                next_val;

    function automatic logic cfg_impl(input logic [cfg_id_width_p-1:0] id);
        return 32'(id) <= 32'd10;
    endfunction

    function automatic logic [9:0] field_value(input logic [cfg_id_width_p-1:0] id,
                                               input logic [2:0] field);
        logic [31:0] id32;
        logic [9:0]  x_dim;
        logic [9:0]  y_dim;
        logic [9:0]  assoc;
        logic [9:0]  coherent;
        logic [9:0]  val;
        id32     = 32'(id);
        x_dim    = 10'd1;
        y_dim    = 10'd1;
        assoc    = 10'd8;
        coherent = 10'd1;
        case (id32)
            32'd1:   begin assoc = 10'd2; coherent = 10'd0; end
            32'd3:   assoc = 10'd2;
            32'd4:   x_dim = 10'd2;
            32'd5:   x_dim = 10'd3;
            32'd6:   begin x_dim = 10'd2; y_dim = 10'd2; end
            32'd7:   begin x_dim = 10'd3; y_dim = 10'd2; end
            32'd8:   begin x_dim = 10'd4; y_dim = 10'd2; end
            32'd9:   begin x_dim = 10'd4; y_dim = 10'd3; end
            32'd10:  begin x_dim = 10'd4; y_dim = 10'd4; end
            default: ;
        endcase
        case (field)
            3'd0:    val = x_dim;
            3'd1:    val = y_dim;
            3'd2:    val = coherent;
            3'd3:    val = 10'd39;
            3'd4:    val = 10'd40;
            3'd5:    val = assoc;
            3'd6:    val = assoc;
            default: val = 10'd512;
        endcase
        // Id 0 is the "inv" config with every field set to 1.
        if (id32 == 32'd0) begin
            val = 10'd1;
        end
        if (!cfg_impl(id)) begin
            val = 10'd0;
        end
        return val;
    endfunction

    assign req_ready_o = ~reset_i & (state_reg == e_idle) & (~resp_v_reg | resp_yumi_i);
    assign accept      = req_v_i & req_ready_o;
    assign first_field = req_dump_i ? 3'd0 : req_field_i;
    assign req_impl    = cfg_impl(cfg_id_i);
    assign req_val     = field_value(cfg_id_i, first_field);
    assign next_field  = resp_field_reg + 3'd1;
    assign next_val    = field_value(cfg_reg, next_field);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg      <= e_idle;
            cfg_reg        <= '0;
            resp_v_reg     <= 1'b0;
            resp_data_reg  <= '0;
            resp_field_reg <= '0;
            resp_err_reg   <= 1'b0;
            resp_last_reg  <= 1'b0;
        end else if (accept) begin
            cfg_reg        <= cfg_id_i;
            resp_v_reg     <= 1'b1;
            resp_data_reg  <= data_width_p'(req_val);
            resp_field_reg <= first_field;
            resp_err_reg   <= ~req_impl;
            resp_last_reg  <= ~(req_dump_i & req_impl);
            state_reg      <= (req_dump_i & req_impl) ? e_dump : e_idle;
        end else if (resp_v_reg && resp_yumi_i) begin
            if (state_reg == e_dump) begin
                resp_data_reg  <= data_width_p'(next_val);
                resp_field_reg <= next_field;
                resp_last_reg  <= (next_field == 3'd7);
                state_reg      <= (next_field == 3'd7) ? e_idle : e_dump;
            end else begin
                resp_v_reg    <= 1'b0;
                resp_last_reg <= 1'b0;
            end
        end
    end

    assign resp_v_o     = resp_v_reg;
    assign resp_data_o  = resp_data_reg;
    assign resp_field_o = resp_field_reg;
    assign resp_err_o   = resp_err_reg;
    assign resp_last_o  = resp_last_reg;

endmodule
